// File: rtl/mac_pe_if.sv
// mac_pe_if: operand/result bundle of one mesh MAC cell.
interface mac_pe_if #(
    parameter int DW = 4,
    parameter int AW = 12
);
    logic          start_i;
    logic          valid_i;
    logic [DW-1:0] a_i;
    logic [DW-1:0] b_i;
    logic [DW-1:0] a_o;
    logic [DW-1:0] b_o;
    logic          valid_o;
    logic [AW-1:0] sum_o;
    logic          sum_valid_o;
    logic          busy_o;

    modport master (
        output start_i, valid_i, a_i, b_i,
        input  a_o, b_o, valid_o, sum_o, sum_valid_o, busy_o
    );
    modport slave (
        input  start_i, valid_i, a_i, b_i,
        output a_o, b_o, valid_o, sum_o, sum_valid_o, busy_o
    );
endinterface

// File: rtl/mac_pe_2dmesh.sv
// mac_pe_2dmesh: systolic MAC cell; forwards A/B east/south one cycle late and
// accumulates K unsigned products into a wrapping AW-bit dot-product term.
module mac_pe_2dmesh #(
    parameter int DW = 4,
    parameter int AW = 12,
    parameter int K  = 4
) (
    input logic    clk_i,
    input logic    rst_ni,
    mac_pe_if.slave pe
);
    localparam int CW = K > 1 ? $clog2(K) : 1;

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t          state_q;
    logic [AW-1:0]   acc_q, acc_d, sum_q;
    logic [CW-1:0]   cnt_q;
    logic [DW-1:0]   a_q, b_q;
    logic            valid_q, sum_valid_q, busy_q;
    logic [2*DW-1:0] prod;
    logic            last;

    assign prod  = pe.a_i * pe.b_i;
    assign acc_d = acc_q + AW'(prod);
    assign last  = cnt_q == CW'(K - 1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            sum_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            valid_q     <= 1'b0;
            sum_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            a_q         <= pe.a_i;
            b_q         <= pe.b_i;
            valid_q     <= pe.valid_i;
            sum_valid_q <= 1'b0;
            case (state_q)
                ACC: if (pe.valid_i) begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (last) begin
                        state_q     <= DONE;
                        sum_q       <= acc_d;
                        sum_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                // IDLE and DONE both accept START; operands in that cycle are dropped
                default: begin
                    state_q <= pe.start_i ? ACC : IDLE;
                    busy_q  <= pe.start_i;
                    if (pe.start_i) begin
                        acc_q <= '0;
                        cnt_q <= '0;
                    end
                end
            endcase
        end
    end

    assign pe.a_o         = a_q;
    assign pe.b_o         = b_q;
    assign pe.valid_o     = valid_q;
    assign pe.sum_o       = sum_q;
    assign pe.sum_valid_o = sum_valid_q;
    assign pe.busy_o      = busy_q;
endmodule

// File: tb/tb_mac_pe_2dmesh.sv
// tb_mac_pe_2dmesh: directed + random checks of the MAC cell against
// dot products computed arithmetically from the applied operand pairs.
module tb_mac_pe_2dmesh;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mac_pe_if #(.DW(4), .AW(12)) pe1 ();
    mac_pe_if #(.DW(6), .AW(12)) pe2 ();

    mac_pe_2dmesh #(.DW(4), .AW(12), .K(4)) u1 (.clk_i(clk), .rst_ni(rst_n), .pe(pe1.slave));
    mac_pe_2dmesh #(.DW(6), .AW(12), .K(4)) u2 (.clk_i(clk), .rst_ni(rst_n), .pe(pe2.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic s, input logic v, input logic [3:0] a, input logic [3:0] b);
        pe1.start_i = s;
        pe1.valid_i = v;
        pe1.a_i     = a;
        pe1.b_i     = b;
    endtask

    task automatic idle_in;
        drive(1'b0, 1'b0, 4'($urandom), 4'($urandom));
    endtask

    // One clock; forwarding of pe1 is checked on every cycle
    task automatic tick;
        logic [3:0] ea, eb;
        logic       ev, r;
        ea = pe1.a_i;
        eb = pe1.b_i;
        ev = pe1.valid_i;
        r  = rst_n;
        @(posedge clk);
        #1;
        chk("fwd_a", 32'(pe1.a_o), r ? 32'(ea) : 32'd0);
        chk("fwd_b", 32'(pe1.b_o), r ? 32'(eb) : 32'd0);
        chk("fwd_v", 32'(pe1.valid_o), r ? 32'(ev) : 32'd0);
    endtask

    task automatic dot(input logic [3:0] pa[4], input logic [3:0] pb[4], input int gap,
                       input bit mid_start, output logic [11:0] res);
        int s;
        s = 0;
        drive(1'b1, 1'b1, 4'($urandom_range(1, 15)), 4'($urandom_range(1, 15)));
        tick;
        chk("start_busy", 32'(pe1.busy_o), 1);
        chk("start_sv", 32'(pe1.sum_valid_o), 0);
        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g < gap; g++) begin
                drive(mid_start && g == 0, 1'b0, 4'($urandom), 4'($urandom));
                tick;
                chk("gap_busy", 32'(pe1.busy_o), 1);
                chk("gap_sv", 32'(pe1.sum_valid_o), 0);
            end
            drive(1'b0, 1'b1, pa[i], pb[i]);
            s += int'(pa[i]) * int'(pb[i]);
            tick;
            if (i < 3) begin
                chk("term_busy", 32'(pe1.busy_o), 1);
                chk("term_sv", 32'(pe1.sum_valid_o), 0);
            end else begin
                chk("done_sv", 32'(pe1.sum_valid_o), 1);
                chk("done_sum", 32'(pe1.sum_o), 32'(s % 4096));
                chk("done_busy", 32'(pe1.busy_o), 0);
            end
        end
        res = 12'(s % 4096);
        idle_in;
    endtask

    task automatic idle_after(input logic [11:0] held);
        tick;
        chk("post_sv", 32'(pe1.sum_valid_o), 0);
        chk("post_busy", 32'(pe1.busy_o), 0);
        chk("post_sum", 32'(pe1.sum_o), 32'(held));
    endtask

    task automatic dot2(input logic [5:0] pa[4], input logic [5:0] pb[4]);
        int s;
        s = 0;
        pe2.start_i = 1'b1;
        pe2.valid_i = 1'b1;
        pe2.a_i = 6'd9;
        pe2.b_i = 6'd9;
        tick;
        pe2.start_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pe2.a_i = pa[i];
            pe2.b_i = pb[i];
            s += int'(pa[i]) * int'(pb[i]);
            tick;
        end
        chk("w_sv", 32'(pe2.sum_valid_o), 1);
        chk("w_sum", 32'(pe2.sum_o), 32'(s % 4096));
        pe2.valid_i = 1'b0;
        tick;
        chk("w_post_sv", 32'(pe2.sum_valid_o), 0);
    endtask

    initial begin
        logic [3:0]  pa[4], pb[4], p15[4], p1[4];
        logic [5:0]  wa[4], wb[4];
        logic [11:0] r;
        int          c1, c2;
        pa  = '{4'd1, 4'd3, 4'd5, 4'd7};
        pb  = '{4'd2, 4'd4, 4'd6, 4'd8};
        p15 = '{4'd15, 4'd15, 4'd15, 4'd15};
        p1  = '{4'd1, 4'd1, 4'd1, 4'd1};
        pe2.start_i = 1'b0;
        pe2.valid_i = 1'b0;
        pe2.a_i = '0;
        pe2.b_i = '0;
        drive(1'b0, 1'b0, 4'd0, 4'd0);

        for (int i = 0; i < 3; i++) begin
            drive(1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom));
            tick;
            chk("rst_sum", 32'(pe1.sum_o), 0);
            chk("rst_sv", 32'(pe1.sum_valid_o), 0);
            chk("rst_busy", 32'(pe1.busy_o), 0);
        end
        idle_in;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            idle_in;
            tick;
            chk("idle_sum", 32'(pe1.sum_o), 0);
            chk("idle_sv", 32'(pe1.sum_valid_o), 0);
            chk("idle_busy", 32'(pe1.busy_o), 0);
        end

        dot(pa, pb, 0, 1'b0, r);
        idle_after(r);
        dot(pa, pb, 2, 1'b1, r);
        idle_after(r);

        dot(pa, pb, 0, 1'b0, r);
        c1 = cyc;
        dot(p15, p15, 0, 1'b0, r);
        c2 = cyc;
        chk("b2b_spacing", 32'(c2 - c1), 5);
        idle_after(r);

        for (int n = 0; n < 8; n++) begin
            logic [3:0] ra[4], rb[4];
            for (int i = 0; i < 4; i++) begin
                ra[i] = 4'($urandom);
                rb[i] = 4'($urandom);
            end
            dot(ra, rb, int'($urandom_range(0, 2)), 1'($urandom), r);
            if (n % 3 == 2) idle_after(r);
        end
        idle_after(r);

        drive(1'b1, 1'b0, 4'd0, 4'd0);
        tick;
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b1, 4'd3, 4'd3);
            tick;
        end
        idle_in;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_sum", 32'(pe1.sum_o), 0);
        chk("mid_rst_sv", 32'(pe1.sum_valid_o), 0);
        chk("mid_rst_busy", 32'(pe1.busy_o), 0);
        chk("mid_rst_a", 32'(pe1.a_o), 0);
        chk("mid_rst_v", 32'(pe1.valid_o), 0);
        for (int i = 0; i < 3; i++) begin
            drive(1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom));
            tick;
            chk("in_rst_sv", 32'(pe1.sum_valid_o), 0);
        end
        idle_in;
        rst_n = 1'b1;
        idle_after(12'd0);
        dot(p1, p1, 0, 1'b0, r);
        idle_after(r);

        wa = '{6'd63, 6'd63, 6'd63, 6'd63};
        dot2(wa, wa);
        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < 4; i++) begin
                wa[i] = 6'($urandom);
                wb[i] = 6'($urandom);
            end
            dot2(wa, wb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
